axi_master_port: RTL and testbench

AXI_MASTER_PORT -- requirements
Module: axi_master_port

---
 rtl/axi_master_port.sv | 208 ++++++++++++++++++++
 tb/tb_axi_master_port.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_port.sv
// -----------------------------------------------------------------------------
// axi_master_port
//
// Bridges a simple blocking CPU load/store port onto an AXI3-style master.
// Each CPU request becomes exactly one single-beat AXI transaction. Reads go
// IDLE -> AR -> R -> DONE and writes go IDLE -> AW -> W -> B -> DONE. The CPU
// is stalled until the DONE cycle.
//
// Parameters
//   MID        ID driven on ARID/AWID for every transaction.
//
// Ports
//   ACLK, ARESETn              clock, synchronous active-low reset
//   cpu_req/cpu_we             request strobe and direction (1 = write)
//   cpu_addr/wdata/wstrb       byte address, write data, byte enables
//   cpu_rdata                  data of the first R beat of the last read
//   cpu_stall                  high while a request is pending and not in DONE
//   cpu_err                    sticky non-OKAY flag for the last transaction
//   AR*/R*                     read address and read data channels
//   AW*/W*/B*                  write address, write data, write response
// -----------------------------------------------------------------------------
module axi_master_port #(
  parameter logic [3:0] MID = 4'd1
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  // CPU side
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  // AR channel
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  // R channel
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  // AW channel
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  // W channel
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  // B channel
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    W    = 3'd4,
    B    = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  // Set on acceptance, cleared after the first R beat; later beats are dropped.
  logic        first_q, first_d;

  // Response IDs are deliberately not compared against MID.
  logic unused_ids;
  assign unused_ids = ^{RID, BID};

  // State and datapath registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Next-state logic and state-decoded handshake outputs. VALID/READY depend
  // on state only, so a VALID is never withdrawn before its handshake and the
  // payload comes from registers latched at acceptance.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    first_d = first_q;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    WLAST   = 1'b0;
    BREADY  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wstrb_d = cpu_wstrb;
          err_d   = 1'b0;
          first_d = 1'b1;
          state_d = cpu_we ? AW : AR;
        end
      end
      AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = R;
      end
      R: begin
        RREADY = 1'b1;
        if (RVALID) begin
          if (first_q) begin
            rdata_d = RDATA;
            err_d   = (RRESP != 2'b00);
            first_d = 1'b0;
          end
          if (RLAST) state_d = DONE;
        end
      end
      AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = W;
      end
      W: begin
        WVALID = 1'b1;
        WLAST  = 1'b1;
        if (WREADY) state_d = B;
      end
      B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          err_d   = (BRESP != 2'b00);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payloads always reflect the latched request; they are only meaningful
  // while the matching VALID is high.
  assign ARID    = MID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;

  assign AWID    = MID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;

  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;

  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  // Combinational so the pipeline is held from the very cycle of the request,
  // including while reset is asserted.
  assign cpu_stall = cpu_req & (state_q != DONE);

endmodule

// File: tb/tb_axi_master_port.sv
module tb_axi_master_port;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN;
  logic [31:0] ARADDR, AWADDR;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, ARREADY, AWVALID, AWREADY;
  logic [3:0]  RID, BID;
  logic [31:0] RDATA, WDATA;
  logic [1:0]  RRESP, BRESP;
  logic        RLAST, RVALID, RREADY;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic        BVALID, BREADY;

  axi_master_port #(.MID(4'd1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl_rdata = 32'd0;
  bit          in_done = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; RDATA = 32'd0; RRESP = 2'b00;
    BVALID = 1'b0; BRESP = 2'b00;
  endtask

  // Drives one CPU request and plays a simple slave. awt = cycles the address
  // READY is withheld, nb = number of R beats, resp = RRESP (first beat) / BRESP.
  task automatic run_txn(input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int awt, input int nb,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [1:0] resp,
                         input bit keep);
    exp_t e;
    int   cyc, vcnt, beat, first_v, ctv, exp_lat;
    bit   done;
    ctv     = in_done ? 2 : 1;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.wstrb = wstrb;
    e.rdata = we ? mdl_rdata : d0;
    e.err   = (resp != 2'b00);
    if (!we) mdl_rdata = d0;
    sb_q.push_back(e);

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    cyc = 0; vcnt = 0; beat = 0; first_v = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge ACLK); #1;
      cyc++;
      clear_slave();
      if (ARVALID || AWVALID) begin
        if (vcnt == 0) begin
          first_v = cyc;
          check_val("stall_busy", {63'd0, cpu_stall}, 64'd1);
          // Scramble CPU inputs; the in-flight transaction must not notice.
          cpu_addr = addr ^ 32'hFFFF_FFF0; cpu_wdata = ~wdata;
          cpu_wstrb = ~wstrb; cpu_we = ~we;
        end
        vcnt++;
        if (we) begin
          check_val("awvalid_only", {62'd0, AWVALID, ARVALID}, 64'd2);
          check_val("awaddr", {32'd0, AWADDR}, {32'd0, addr});
          check_val("aw_const", {51'd0, AWID, AWLEN, AWSIZE, AWBURST},
                    {51'd0, 4'd1, 4'd0, 3'b010, 2'b01});
          if (vcnt > awt) AWREADY = 1'b1;
        end else begin
          check_val("arvalid_only", {62'd0, AWVALID, ARVALID}, 64'd1);
          check_val("araddr", {32'd0, ARADDR}, {32'd0, addr});
          check_val("ar_const", {51'd0, ARID, ARLEN, ARSIZE, ARBURST},
                    {51'd0, 4'd1, 4'd0, 3'b010, 2'b01});
          if (vcnt > awt) ARREADY = 1'b1;
        end
      end else if (RREADY) begin
        RVALID = 1'b1;
        RDATA  = (beat == 0) ? d0 : ((beat == 1) ? d1 : d2);
        RRESP  = (beat == 0) ? resp : 2'b00;
        RLAST  = (beat == nb - 1);
        RID    = 4'hF;  // wrong ID on purpose; must be ignored
        beat++;
      end else if (WVALID) begin
        check_val("wdata", {32'd0, WDATA}, {32'd0, wdata});
        check_val("wstrb_wlast", {59'd0, WSTRB, WLAST}, {59'd0, wstrb, 1'b1});
        WREADY = 1'b1;
      end else if (BREADY) begin
        BVALID = 1'b1;
        BRESP  = resp;
        BID    = 4'hE;
      end else if (cpu_req && !cpu_stall) begin
        done = 1'b1;
      end
    end

    e = sb_q.pop_front();
    if (!done) begin
      check_val("timeout", 64'd0, 64'd1);
    end else begin
      exp_lat = ctv + awt + 1 + (we ? 2 : nb);
      check_val("first_valid_cycle", 64'(first_v), 64'(ctv));
      check_val("addr_valid_cycles", 64'(vcnt), 64'(awt + 1));
      check_val("done_latency", 64'(cyc), 64'(exp_lat));
      check_val("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e.rdata});
      check_val("cpu_err", {63'd0, cpu_err}, {63'd0, e.err});
      check_val("done_quiet", {59'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 64'd0);
    end
    $display("txn %s addr=%08h lat=%0d rdata=%08h err=%0d", e.we ? "WR" : "RD",
             e.addr, cyc, cpu_rdata, cpu_err);
    in_done = 1'b1;
    if (!keep) cpu_req = 1'b0;
  endtask

  initial begin
    RID = 4'd1; BID = 4'd1;
    clear_slave();
    ARESETn = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
    cpu_wdata = 32'd0; cpu_wstrb = 4'd0;
    repeat (3) @(posedge ACLK);
    #1;
    // Reset with a pending request: stalled, no AXI activity.
    check_val("rst_stall", {63'd0, cpu_stall}, 64'd1);
    check_val("rst_quiet", {59'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 64'd0);
    check_val("rst_rdata_err", {31'd0, cpu_rdata, cpu_err}, 64'd0);
    cpu_req = 1'b0;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check_val("idle_quiet", {59'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 64'd0);

    // Zero-wait read
    run_txn(1'b0, 32'h0000_0010, 32'd0, 4'd0, 0, 1, 32'hDEAD_BEEF, 32'd0, 32'd0, 2'b00, 1'b0);
    // Write with AWREADY held off 3 cycles; rdata must be untouched
    run_txn(1'b1, 32'h0001_0004, 32'h1234_5678, 4'b0011, 3, 1, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    // Three-beat read: only the first beat is kept
    run_txn(1'b0, 32'h0000_0020, 32'd0, 4'd0, 1, 3, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 2'b00, 1'b0);
    // Write with SLVERR, then an OKAY read clears the flag
    run_txn(1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'b1111, 0, 1, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0);
    run_txn(1'b0, 32'h0000_0030, 32'd0, 4'd0, 0, 1, 32'h0000_55AA, 32'd0, 32'd0, 2'b00, 1'b1);
    // Back-to-back with cpu_req held high through DONE
    run_txn(1'b0, 32'h0000_0040, 32'd0, 4'd0, 0, 1, 32'h1357_9BDF, 32'd0, 32'd0, 2'b00, 1'b1);
    // Read with DECERR on the first beat
    run_txn(1'b0, 32'h0000_0044, 32'd0, 4'd0, 2, 2, 32'h2468_ACE0, 32'h1111_2222, 32'd0, 2'b11, 1'b0);

    // Reset while waiting in R with RVALID low
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0050;
    @(posedge ACLK); #1;              // DONE -> IDLE
    @(posedge ACLK); #1;              // IDLE -> AR
    check_val("mid_arvalid", {63'd0, ARVALID}, 64'd1);
    ARREADY = 1'b1;
    @(posedge ACLK); #1;              // AR -> R
    check_val("mid_rready", {63'd0, RREADY}, 64'd1);
    clear_slave();
    cpu_req = 1'b0;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    check_val("mid_rst_quiet", {59'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 64'd0);
    check_val("mid_rst_rdata_err", {31'd0, cpu_rdata, cpu_err}, 64'd0);
    ARESETn = 1'b1;
    mdl_rdata = 32'd0;
    in_done = 1'b0;
    @(posedge ACLK); #1;
    check_val("post_rst_quiet", {59'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 64'd0);

    // Write after reset keeps the cleared rdata, then a normal read
    run_txn(1'b1, 32'h0000_0060, 32'h8765_4321, 4'b1100, 1, 1, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    run_txn(1'b0, 32'h0000_0064, 32'd0, 4'd0, 0, 1, 32'h0BAD_F00D, 32'd0, 32'd0, 2'b00, 1'b0);

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
